// File: rtl/pwm_pkg.sv
// Shared widths, types and reset constants for the PWM generator and its sequencer.
// Helper functions keep the boundary and duty decisions identical wherever they are used.
package pwm_pkg;

  localparam int unsigned TOP_W   = 8;
  localparam int unsigned CMP_W   = 9;
  localparam int unsigned PRESC_W = 16;

  typedef logic [TOP_W-1:0]   top_t;
  typedef logic [CMP_W-1:0]   cmp_t;
  typedef logic [PRESC_W-1:0] presc_t;

  localparam top_t RESET_TOP_DEFAULT = 8'hFF;
  localparam top_t RESET_COUNT       = '0;
  localparam cmp_t RESET_COMPARE     = '0;

  // A pending field: value waiting for the next period boundary plus its flag.
  typedef struct packed {
    logic valid;
    top_t value;
  } top_pend_t;

  typedef struct packed {
    logic valid;
    cmp_t value;
  } cmp_pend_t;

  localparam top_pend_t TOP_PEND_RESET = '{valid: 1'b0, value: RESET_COUNT};
  localparam cmp_pend_t CMP_PEND_RESET = '{valid: 1'b0, value: RESET_COMPARE};

  // Compare is one bit wider than the counter so a full-scale value gives 100% duty.
  function automatic logic pwm_level(input top_t count, input cmp_t compare);
    return ({1'b0, count} < compare);
  endfunction

  function automatic logic at_boundary(input logic tick, input top_t count, input top_t top);
    return tick && (count >= top);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Tick generator: one-cycle o_tick every PRESCALE clock cycles.
// The tick is decoded from the slot register, so it carries no input-to-output path.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam presc_t LastSlot = presc_t'(PRESCALE - 1);

  presc_t slot_q;
  presc_t slot_d;

  always_comb begin
    o_tick = (slot_q == LastSlot);
    slot_d = o_tick ? '0 : slot_q + presc_t'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/pwm_generator.sv
// PWM generator with programmable top/compare; PWM_GENERATOR_SYNC_UPDATE_EN defers
// strobed values to the next period boundary, otherwise they take effect next cycle.
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int unsigned      PRESCALE  = 1,
  parameter logic [TOP_W-1:0] RESET_TOP = RESET_TOP_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [TOP_W-1:0] i_top,
  input  logic             i_top_valid,
  input  logic [CMP_W-1:0] i_compare,
  input  logic             i_compare_valid,
  output logic             o_pwm,
  output logic             o_period_start,
  output logic             o_applied
);

  logic tick;

  pwm_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .o_tick (tick)
  );

  top_t count_q;
  top_t count_d;
  top_t top_q;
  top_t top_d;
  cmp_t compare_q;
  cmp_t compare_d;
  logic period_start_q;
  logic applied_q;
  logic applied_d;
  logic boundary;

  assign boundary = at_boundary(tick, count_q, top_q);

  always_comb begin
    count_d = count_q;
    if (tick) begin
      count_d = boundary ? RESET_COUNT : count_q + top_t'(1);
    end
  end

`ifdef PWM_GENERATOR_SYNC_UPDATE_EN
  top_pend_t top_pend_q;
  top_pend_t top_pend_d;
  cmp_pend_t cmp_pend_q;
  cmp_pend_t cmp_pend_d;

  always_comb begin
    top_pend_d = top_pend_q;
    cmp_pend_d = cmp_pend_q;
    top_d      = top_q;
    compare_d  = compare_q;
    applied_d  = 1'b0;
    if (boundary) begin
      // A strobe landing on the boundary is forwarded, so no flag survives it.
      if (i_top_valid) begin
        top_d = i_top;
      end else if (top_pend_q.valid) begin
        top_d = top_pend_q.value;
      end
      if (i_compare_valid) begin
        compare_d = i_compare;
      end else if (cmp_pend_q.valid) begin
        compare_d = cmp_pend_q.value;
      end
      applied_d = i_top_valid | top_pend_q.valid | i_compare_valid | cmp_pend_q.valid;
      top_pend_d.valid = 1'b0;
      cmp_pend_d.valid = 1'b0;
    end else begin
      if (i_top_valid) begin
        top_pend_d = '{valid: 1'b1, value: i_top};
      end
      if (i_compare_valid) begin
        cmp_pend_d = '{valid: 1'b1, value: i_compare};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      top_pend_q <= TOP_PEND_RESET;
      cmp_pend_q <= CMP_PEND_RESET;
    end else begin
      top_pend_q <= top_pend_d;
      cmp_pend_q <= cmp_pend_d;
    end
  end
`else
  // Direct update; an oversized count simply wraps on the next tick.
  always_comb begin
    top_d     = i_top_valid ? i_top : top_q;
    compare_d = i_compare_valid ? i_compare : compare_q;
    applied_d = i_top_valid | i_compare_valid;
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q        <= RESET_COUNT;
      top_q          <= RESET_TOP;
      compare_q      <= RESET_COMPARE;
      period_start_q <= 1'b0;
      applied_q      <= 1'b0;
    end else begin
      count_q        <= count_d;
      top_q          <= top_d;
      compare_q      <= compare_d;
      period_start_q <= boundary;
      applied_q      <= applied_d;
    end
  end

  assign o_pwm          = pwm_level(count_q, compare_q);
  assign o_period_start = period_start_q;
  assign o_applied      = applied_q;

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator: one instance at PRESCALE=1, one at PRESCALE=4.
module tb_pwm_generator;
  import pwm_pkg::*;

`ifdef PWM_GENERATOR_SYNC_UPDATE_EN
  localparam bit Sync = 1'b1;
`else
  localparam bit Sync = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, top_valid, compare_valid, pwm, ps, applied;
  top_t top;
  cmp_t compare;
  logic rst4_n, top4_valid, cmp4_valid, pwm4, ps4, applied4;
  top_t top4;
  cmp_t cmp4;

  int checks = 0;
  int errors = 0;
  int n;

  pwm_generator #(
    .PRESCALE(1)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_top          (top),
    .i_top_valid    (top_valid),
    .i_compare      (compare),
    .i_compare_valid(compare_valid),
    .o_pwm          (pwm),
    .o_period_start (ps),
    .o_applied      (applied)
  );

  pwm_generator #(
    .PRESCALE(4)
  ) dut4 (
    .i_clk          (clk),
    .i_rst_n        (rst4_n),
    .i_top          (top4),
    .i_top_valid    (top4_valid),
    .i_compare      (cmp4),
    .i_compare_valid(cmp4_valid),
    .o_pwm          (pwm4),
    .o_period_start (ps4),
    .o_applied      (applied4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step until the selected instance shows a period start, within a cycle budget.
  task automatic wait_ps(input bit which, input int budget, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (((which ? ps4 : ps) !== 1'b1) && (cnt < budget));
    check(which ? "ps4_reached" : "ps_reached", {31'd0, which ? ps4 : ps}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; top = '0; top_valid = 1'b0; compare = '0; compare_valid = 1'b0;
    rst4_n = 1'b0; top4 = '0; top4_valid = 1'b0; cmp4 = '0; cmp4_valid = 1'b0;

    // Reset state of both instances
    #22;
    check("rst_pwm", pwm, 0);
    check("rst_ps", ps, 0);
    check("rst_applied", applied, 0);
    check("rst4_pwm", pwm4, 0);
    check("rst4_ps", ps4, 0);
    check("rst4_applied", applied4, 0);

    // Default config: period of 256 ticks, duty 0
    tick();
    rst_n = 1'b1;
    wait_ps(1'b0, 300, n);
    check("first_period_len", n, 256);
    wait_ps(1'b0, 300, n);
    check("period_len", n, 256);
    check("default_pwm", pwm, 0);
    check("default_applied", applied, 0);

    // top=3, compare=2 -> 1,1,0,0
    top = 8'd3; top_valid = 1'b1; compare = 9'd2; compare_valid = 1'b1;
    tick();
    top_valid = 1'b0; compare_valid = 1'b0;
    check("applied_after_strobe", applied, !Sync);
    wait_ps(1'b0, 300, n);
    check("applied_at_boundary", applied, Sync);
    for (int i = 0; i < 8; i++) begin
      check("pat_pwm", pwm, (i % 4) < 2);
      check("pat_ps", ps, (i % 4) == 0);
      tick();
    end

    // 100% duty with compare=0x100 at top=0xFF
    top = 8'hFF; top_valid = 1'b1; compare = 9'h100; compare_valid = 1'b1;
    tick();
    top_valid = 1'b0; compare_valid = 1'b0;
    wait_ps(1'b0, 300, n);
    for (int i = 0; i < 256; i++) begin
      check("full_pwm", pwm, 1);
      tick();
    end
    check("full_ps", ps, 1);

    // compare=0 -> constantly low
    compare = 9'd0; compare_valid = 1'b1;
    tick();
    compare_valid = 1'b0;
    wait_ps(1'b0, 300, n);
    for (int i = 0; i < 256; i++) begin
      check("zero_pwm", pwm, 0);
      tick();
    end
    check("zero_ps", ps, 1);

    // Mid-period compare update at count=100
    repeat (100) tick();
    compare = 9'h080; compare_valid = 1'b1;
    tick();
    compare_valid = 1'b0;
    check("mid_applied", applied, !Sync);
    for (int c = 101; c < 256; c++) begin
      check("mid_pwm", pwm, Sync ? 1'b0 : (c < 128));
      tick();
    end
    check("mid_end_ps", ps, 1);
    check("mid_end_applied", applied, Sync);
    check("mid_end_pwm", pwm, 1);

    // Strobe coincident with the boundary tick
    repeat (255) tick();
    check("pre_boundary_ps", ps, 0);
    compare = 9'h040; compare_valid = 1'b1;
    tick();
    compare_valid = 1'b0;
    check("coinc_ps", ps, 1);
    check("coinc_applied", applied, 1);
    check("coinc_pwm", pwm, 1);
    repeat (63) tick();
    check("coinc_pwm_63", pwm, 1);
    tick();
    check("coinc_pwm_64", pwm, 0);
    wait_ps(1'b0, 300, n);
    check("coinc_rest_len", n, 192);
    check("coinc_no_leftover", applied, 0);

    // Last strobe wins
    compare = 9'h010; compare_valid = 1'b1;
    tick();
    compare = 9'h020;
    tick();
    compare_valid = 1'b0;
    wait_ps(1'b0, 300, n);
    repeat (24) tick();
    check("last_wins_pwm", pwm, 1);

    // PRESCALE=4, top=1, compare=1 -> 8-cycle period, high for 4
    rst4_n = 1'b1;
    top4 = 8'd1; top4_valid = 1'b1; cmp4 = 9'd1; cmp4_valid = 1'b1;
    tick();
    top4_valid = 1'b0; cmp4_valid = 1'b0;
    wait_ps(1'b1, 1100, n);
    for (int i = 0; i < 16; i++) begin
      check("p4_pwm", pwm4, (i % 8) < 4);
      check("p4_ps", ps4, (i % 8) == 0);
      tick();
    end
    cmp4 = 9'd2; cmp4_valid = 1'b1;
    tick();
    cmp4_valid = 1'b0;
    wait_ps(1'b1, 20, n);
    check("p4_period_len", n, 7);

    // Asynchronous reset at count=1
    repeat (5) tick();
    check("p4_pwm_before_rst", pwm4, 1);
    rst4_n = 1'b0;
    #1;
    check("p4_rst_pwm", pwm4, 0);
    check("p4_rst_ps", ps4, 0);
    check("p4_rst_applied", applied4, 0);
    tick();
    tick();
    check("p4_rst_hold_pwm", pwm4, 0);
    rst4_n = 1'b1;
    wait_ps(1'b1, 1100, n);
    check("p4_restart_len", n, 1024);
    check("p4_restart_pwm", pwm4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_generator.md
PWM_GENERATOR -- requirements
Module: pwm_generator

Interface
REQ-001 SHALL have parameter PRESCALE, default 1, meaning i_clk cycles per counter tick (legal range 1..65535).
REQ-002 SHALL have parameter RESET_TOP, default 8'hFF, meaning the active top value after reset.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port i_top, input, 8 bits: requested period top (period = top+1 ticks).
REQ-006 SHALL have port i_top_valid, input, 1 bit: i_top qualifier, one-cycle strobe.
REQ-007 SHALL have port i_compare, input, 9 bits: requested compare (duty = compare/(top+1)).
REQ-008 SHALL have port i_compare_valid, input, 1 bit: i_compare qualifier, one-cycle strobe.
REQ-009 SHALL have port o_pwm, output, 1 bit: PWM waveform.
REQ-010 SHALL have port o_period_start, output, 1 bit: one-cycle pulse in the first cycle of each period.
REQ-011 SHALL have port o_applied, output, 1 bit: one-cycle pulse when a pending value becomes active.

Function
REQ-012 SHALL produce a tick every PRESCALE cycles from a prescale counter 0..PRESCALE-1; with PRESCALE=1, a tick every cycle.
REQ-013 SHALL advance the 8-bit period counter r_count on each tick and wrap it to 0 on a tick when r_count >= active_top (the boundary event).
REQ-014 SHALL drive o_pwm = (r_count < active_compare), derived only from registers with no combinational path from inputs.
REQ-015 SHALL, for compare 0, hold o_pwm low; for compare > active_top, hold it high (9-bit compare permits 100% duty at top=8'hFF).
REQ-016 SHALL capture i_top / i_compare into independent pending registers on their valid strobes and set per-field pending flags; a later strobe before application overwrites the earlier one (last wins).
REQ-017 SHALL, at the boundary event, copy each pending field to its active register and clear its flag; fields without a flag are unchanged.
REQ-018 SHALL, if a valid strobe coincides with the boundary event, apply that same-cycle value at this boundary (forwarded) and leave no flag set.
REQ-019 SHALL assert o_period_start, registered, for exactly one cycle following each boundary event (the cycle with r_count==0, the first prescale slot).
REQ-020 SHALL assert o_applied, registered, for one cycle aligned with o_period_start whenever at least one field was applied.
REQ-021 SHALL accept strobes on every cycle, with no backpressure and no input dropped except by last-wins overwrite.

Reset
REQ-022 SHALL, while i_rst_n is low, hold prescale=0, r_count=0, active_top=RESET_TOP, active_compare=0, pending flags clear, o_pwm=0, o_period_start=0, o_applied=0.
REQ-023 SHALL, on reset assertion mid-period, abort immediately and discard pending values; after release, the first period starts at r_count=0 without an o_period_start pulse.

Configuration
REQ-024 SHALL, with macro PWM_GENERATOR_SYNC_UPDATE_EN defined, behave as REQ-016..REQ-018 (glitch-free updates at period boundaries).
REQ-025 SHALL, without PWM_GENERATOR_SYNC_UPDATE_EN, write strobed values directly to the active registers the next cycle with no pending registers; if r_count then exceeds active_top, the next tick wraps per REQ-013; o_applied pulses one cycle after each accepted strobe.

Structure
REQ-026 SHALL take the widths TOP_W=8 and CMP_W=9 and the reset constants from shared package pwm_pkg, which the sequencer also uses.
REQ-027 SHALL implement the tick generator as sub-module pwm_prescaler (ports i_clk, i_rst_n, o_tick).

Verification
REQ-028 SHALL cover: reset, PRESCALE=1, no strobes -> o_pwm low, o_period_start every 256 cycles.
REQ-029 SHALL cover: top=3, compare=2 applied -> o_pwm pattern 1,1,0,0 repeating; period 4 cycles.
REQ-030 SHALL cover: compare=9'h100 at top=8'hFF -> o_pwm constantly high; compare=0 -> constantly low.
REQ-031 SHALL cover: sync build, compare strobed mid-period (r_count=100, top=255) -> old duty to period end; new value and o_applied at next o_period_start.
REQ-032 SHALL cover: strobe coincident with the boundary tick -> value active in the immediately following period, flag clear.
REQ-033 SHALL cover: PRESCALE=4, top=1 -> period 8 cycles; i_rst_n low at r_count=1 -> outputs 0 asynchronously, restart at r_count=0.
